regfile_wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared write-back types and default widths for the register file and its write-back arbiter.
package wb_pkg;

    localparam int REG_DATA_WIDTH     = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_DEPTH      = 32;
    localparam int LSU_FIFO_DEPTH     = 2;
    localparam int FIFO_PTR_WIDTH     = $clog2(LSU_FIFO_DEPTH);

    typedef struct packed {
        logic [REGFILE_ADDR_WIDTH-1:0] rd;
        logic [REG_DATA_WIDTH-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for long-latency results; power-of-two depth so both pointers wrap naturally.
module wb_fifo #(
    parameter  int DEPTH = wb_pkg::LSU_FIFO_DEPTH,
    parameter  int WIDTH = $bits(wb_pkg::wb_req_t),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and buffered LSU/MUL results onto the single register-file write port.
// Define WB_SCOREBOARD_EN to build the per-register busy-bit scoreboard; otherwise busy_o is 0.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int REG_DATA_WIDTH     = wb_pkg::REG_DATA_WIDTH,
    parameter int REGFILE_ADDR_WIDTH = wb_pkg::REGFILE_ADDR_WIDTH,
    parameter int REGFILE_DEPTH      = wb_pkg::REGFILE_DEPTH,
    parameter int LSU_FIFO_DEPTH     = wb_pkg::LSU_FIFO_DEPTH
) (
    input  logic                              clk_i,
    input  logic                              resetn_i,
    input  logic                              alu_valid_i,
    output logic                              alu_ready_o,
    input  logic [REGFILE_ADDR_WIDTH-1:0]     alu_rd_i,
    input  logic [REG_DATA_WIDTH-1:0]         alu_data_i,
    input  logic                              lsu_valid_i,
    output logic                              lsu_ready_o,
    input  logic [REGFILE_ADDR_WIDTH-1:0]     lsu_rd_i,
    input  logic [REG_DATA_WIDTH-1:0]         lsu_data_i,
    input  logic                              issue_en_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0]     issue_rd_i,
    output logic [REGFILE_ADDR_WIDTH-1:0]     rd_addr_o,
    output logic [REG_DATA_WIDTH-1:0]         rd_wr_data_o,
    output logic                              rd_wr_en_o,
    output logic [REGFILE_DEPTH-1:0]          busy_o,
    output logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count_o
);

    wb_req_t                         w_lsu_req;
    wb_req_t                         w_head;
    logic                            w_full;
    logic                            w_empty;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_alu_wr;
    logic                            w_wr_en;
    logic [REGFILE_ADDR_WIDTH-1:0]   w_wr_rd;
    logic [REG_DATA_WIDTH-1:0]       w_wr_data;

    logic                            r_wr_en;
    logic [REGFILE_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [REG_DATA_WIDTH-1:0]       r_wr_data;

    // A full buffer stalls the ALU so the head can drain; readiness never looks at valids.
    assign alu_ready_o = !w_full;
    assign lsu_ready_o = !w_full;

    assign w_lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};
    assign w_push    = lsu_valid_i && !w_full && (lsu_rd_i != '0);
    assign w_alu_wr  = alu_valid_i && !w_full && (alu_rd_i != '0);
    assign w_pop     = !w_empty && !w_alu_wr;

    wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push_i   (w_push),
        .pop_i    (w_pop),
        .data_i   (w_lsu_req),
        .data_o   (w_head),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .count_o  (fifo_count_o)
    );

    always_comb begin
        w_wr_en   = w_alu_wr || w_pop;
        w_wr_rd   = w_alu_wr ? alu_rd_i   : w_head.rd;
        w_wr_data = w_alu_wr ? alu_data_i : w_head.data;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= w_wr_rd;
                r_wr_data <= w_wr_data;
            end
        end
    end

    assign rd_wr_en_o   = r_wr_en;
    assign rd_addr_o    = r_wr_addr;
    assign rd_wr_data_o = r_wr_data;

`ifdef WB_SCOREBOARD_EN
    logic [REGFILE_DEPTH-1:0] r_busy;
    logic [REGFILE_DEPTH-1:0] w_busy_set;
    logic [REGFILE_DEPTH-1:0] w_busy_clr;

    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_en_i && (issue_rd_i != '0)) w_busy_set[issue_rd_i] = 1'b1;
        if (w_wr_en)                          w_busy_clr[w_wr_rd]    = 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) r_busy <= '0;
        else           r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~REGFILE_DEPTH'(1);
    end

    assign busy_o = r_busy;
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{issue_en_i, issue_rd_i};
    assign busy_o         = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-based reference model, decoupled write monitor.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RD = 32;
    localparam int FD = 2;
    localparam int CW = $clog2(FD) + 1;

    logic          clk_i = 1'b0;
    logic          resetn_i = 1'b0;
    logic          alu_valid_i = 1'b0;
    logic          alu_ready_o;
    logic [AW-1:0] alu_rd_i = '0;
    logic [DW-1:0] alu_data_i = '0;
    logic          lsu_valid_i = 1'b0;
    logic          lsu_ready_o;
    logic [AW-1:0] lsu_rd_i = '0;
    logic [DW-1:0] lsu_data_i = '0;
    logic          issue_en_i = 1'b0;
    logic [AW-1:0] issue_rd_i = '0;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_wr_data_o;
    logic          rd_wr_en_o;
    logic [RD-1:0] busy_o;
    logic [CW-1:0] fifo_count_o;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter #(
        .REG_DATA_WIDTH     (DW),
        .REGFILE_ADDR_WIDTH (AW),
        .REGFILE_DEPTH      (RD),
        .LSU_FIFO_DEPTH     (FD)
    ) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .issue_en_i   (issue_en_i),
        .issue_rd_i   (issue_rd_i),
        .rd_addr_o    (rd_addr_o),
        .rd_wr_data_o (rd_wr_data_o),
        .rd_wr_en_o   (rd_wr_en_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; int cyc; } exp_t;
    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;

    exp_t          exp_q[$];
    ent_t          fifo_q[$];
    logic [RD-1:0] m_busy = '0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    logic          alu_pend = 1'b0;
    logic [AW-1:0] h_ard;
    logic [DW-1:0] h_adat;
    logic          lsu_pend = 1'b0;
    logic [AW-1:0] h_lrd;
    logic [DW-1:0] h_ldat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every presented write must be the oldest expected one, on its expected cycle.
    always @(negedge clk_i) begin
        if (resetn_i) begin
            if (rd_wr_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, expected no write (cycle %0d)",
                             rd_addr_o, rd_wr_data_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(rd_addr_o), 64'(e.rd));
                    check("wr_data", 64'(rd_wr_data_o), 64'(e.data));
                    check("wr_cycle", 64'(cyc), 64'(e.cyc));
                    last_addr = e.rd;
                    last_data = e.data;
                end
            end else begin
                check("hold_addr", 64'(rd_addr_o), 64'(last_addr));
                check("hold_data", 64'(rd_wr_data_o), 64'(last_data));
            end
            check("busy", 64'(busy_o), 64'(m_busy));
        end
    end

    // One clock of stimulus; a source that was stalled keeps presenting its held result.
    task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                        input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                        input logic ie, input logic [AW-1:0] ird);
        bit   full;
        ent_t h;
        int   wrote;
        @(negedge clk_i);
        if (alu_pend) begin av = 1'b1; ard = h_ard; adat = h_adat; end
        if (lsu_pend) begin lv = 1'b1; lrd = h_lrd; ldat = h_ldat; end
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = adat;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ldat;
        issue_en_i  = ie; issue_rd_i = ird;
        #1;
        full = (fifo_q.size() == FD);
        check("alu_ready", 64'(alu_ready_o), 64'(!full));
        check("lsu_ready", 64'(lsu_ready_o), 64'(!full));
        check("fifo_count", 64'(fifo_count_o), 64'(fifo_q.size()));
        wrote = 0;
        if (av && !full && ard != 0) begin
            exp_q.push_back('{ard, adat, cyc + 1});
            wrote = int'(ard);
        end else if (fifo_q.size() != 0) begin
            h = fifo_q.pop_front();
            exp_q.push_back('{h.rd, h.data, cyc + 1});
            wrote = int'(h.rd);
        end
        if (lv && !full && lrd != 0) fifo_q.push_back('{lrd, ldat});
`ifdef WB_SCOREBOARD_EN
        if (wrote != 0)         m_busy[wrote] = 1'b0;
        if (ie && ird != 0)     m_busy[ird]   = 1'b1;
`endif
        alu_pend = av && full;  h_ard = ard; h_adat = adat;
        lsu_pend = lv && full;  h_lrd = lrd; h_ldat = ldat;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        resetn_i = 1'b0;
        #1;
        check("rst_wr_en", 64'(rd_wr_en_o), 64'd0);
        check("rst_addr", 64'(rd_addr_o), 64'd0);
        check("rst_data", 64'(rd_wr_data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_count", 64'(fifo_count_o), 64'd0);
        check("rst_lsu_ready", 64'(lsu_ready_o), 64'd1);
        check("rst_alu_ready", 64'(alu_ready_o), 64'd1);
        fifo_q.delete();
        exp_q.delete();
        m_busy = '0; last_addr = '0; last_data = '0;
        alu_pend = 1'b0; lsu_pend = 1'b0;
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; issue_en_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        resetn_i = 1'b1;
    endtask

    initial begin
        #1;
        check("init_wr_en", 64'(rd_wr_en_o), 64'd0);
        check("init_addr", 64'(rd_addr_o), 64'd0);
        check("init_count", 64'(fifo_count_o), 64'd0);
        check("init_lsu_ready", 64'(lsu_ready_o), 64'd1);
        check("init_busy", 64'(busy_o), 64'd0);
        #11;
        resetn_i = 1'b1;

        // ALU single-cycle write.
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(2);
        // LSU result through an empty buffer with the ALU idle.
        step(0, 0, 0, 1, 7, 32'h11, 0, 0);
        idle(3);
        // Fill the buffer while the ALU is valid every cycle.
        step(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0);
        step(1, 3, 32'hA3, 1, 4, 32'hB4, 0, 0);
        step(1, 5, 32'hA5, 1, 6, 32'hB6, 0, 0);
        step(1, 8, 32'hA8, 1, 10, 32'hBA, 0, 0);
        step(1, 11, 32'hAB, 0, 0, 0, 0, 0);
        step(1, 12, 32'hAC, 0, 0, 0, 0, 0);
        idle(4);
        // Register 0 from both sources, then rd=0 ALU while the buffer drains.
        step(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
        step(0, 0, 0, 1, 13, 32'h77, 0, 0);
        step(1, 0, 32'h88, 0, 0, 0, 0, 0);
        idle(2);
        // Same-cycle clear and reissue of r9, then a lone clearing write.
        step(0, 0, 0, 0, 0, 0, 1, 9);
        step(1, 9, 32'h99, 0, 0, 0, 1, 9);
        idle(1);
        step(1, 9, 32'h9A, 0, 0, 0, 0, 0);
        idle(2);
        // Reset with two buffered entries and pending busy bits.
        step(1, 14, 32'hC1, 1, 15, 32'hC2, 1, 20);
        step(1, 16, 32'hC3, 1, 17, 32'hC4, 1, 21);
        do_reset();
        idle(4);

        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] ard;
            logic [AW-1:0] lrd;
            ard = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 31));
            lrd = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 31));
            step($urandom_range(0, 99) < 60, ard, $urandom,
                 $urandom_range(0, 99) < 45, lrd, $urandom,
                 $urandom_range(0, 99) < 30, AW'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 20 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) idle(1);
        @(negedge clk_i);
        #1;
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        check("drain_count", 64'(fifo_count_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
